// File: rtl/ft2232h_frame_tx.sv
// Serialises a latched sample frame onto the FT2232H synchronous FIFO bus:
// optional header byte, optional sequence byte, then payload MSB-first.
module ft2232h_frame_tx #(
  parameter int unsigned DATA_WIDTH  = 14,
  parameter int unsigned NUM_SAMPLES = 40,
  parameter int unsigned HEADER_EN   = 1,
  parameter logic [7:0]  HEADER_BYTE = 8'hFF,
  parameter int unsigned SEQ_EN      = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH*NUM_SAMPLES-1:0] frame_data,
  input  logic                              frame_valid,
  output logic                              frame_ready,
  input  logic                              txe,
  output logic                              wr,
  output logic [7:0]                        data_out,
  output logic                              busy,
  output logic [15:0]                       frame_count
);

  localparam int unsigned PAYLOAD_BITS_IN = DATA_WIDTH * NUM_SAMPLES;
  localparam int unsigned PAYLOAD_BYTES   = (PAYLOAD_BITS_IN + 7) / 8;
  localparam int unsigned PAYLOAD_BITS    = PAYLOAD_BYTES * 8;
  localparam int unsigned PAD_BITS        = PAYLOAD_BITS - PAYLOAD_BITS_IN;
  localparam int unsigned FRAME_BYTES     = PAYLOAD_BYTES + HEADER_EN + SEQ_EN;
  localparam int unsigned IDX_W           = $clog2(FRAME_BYTES + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                     r_state;
  logic [PAYLOAD_BITS_IN-1:0] r_buf;
  logic [IDX_W-1:0]           r_idx;
  logic [7:0]                 r_seq;
  logic [7:0]                 r_data;
  logic                       r_wr;
  logic [15:0]                r_count;

  logic [PAYLOAD_BITS_IN-1:0] w_raw;
  logic [PAYLOAD_BITS-1:0]    w_src;
  logic [IDX_W-1:0]           w_sel_idx;
  logic [7:0]                 w_byte;
  logic                       w_last;
  logic                       w_xfer;

  // In IDLE byte 0 comes straight from frame_data, since the buffer loads on the same edge.
  assign w_raw     = (r_state == S_IDLE) ? frame_data : r_buf;
  assign w_src     = PAYLOAD_BITS'(w_raw) << PAD_BITS;
  assign w_sel_idx = (r_state == S_IDLE) ? IDX_W'(0) : r_idx + IDX_W'(1);
  assign w_last    = (r_idx == IDX_W'(FRAME_BYTES - 1));
  assign w_xfer    = !r_wr && !txe;

  // Byte selector: header, sequence number, then left-justified payload bytes.
  always_comb begin
    w_byte = 8'h00;
    if ((HEADER_EN != 0) && (w_sel_idx == IDX_W'(0))) begin
      w_byte = HEADER_BYTE;
    end else if ((SEQ_EN != 0) && (w_sel_idx == IDX_W'(HEADER_EN))) begin
      w_byte = r_seq;
    end else begin
      for (int unsigned i = 0; i < PAYLOAD_BYTES; i++) begin
        if (w_sel_idx == IDX_W'(i + HEADER_EN + SEQ_EN)) begin
          w_byte = w_src[PAYLOAD_BITS-1-8*i -: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_buf   <= '0;
      r_idx   <= '0;
      r_seq   <= 8'h00;
      r_data  <= 8'h00;
      r_wr    <= 1'b1;
      r_count <= 16'h0000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_valid) begin
            r_buf   <= frame_data;
            r_state <= S_SEND;
            r_wr    <= 1'b0;
            r_data  <= w_byte;
            r_idx   <= '0;
          end
        end
        S_SEND: begin
          // txe high simply stalls: index and data hold, wr stays asserted.
          if (w_xfer) begin
            if (w_last) begin
              r_state <= S_IDLE;
              r_wr    <= 1'b1;
              r_idx   <= '0;
              r_count <= r_count + 16'd1;
              r_seq   <= r_seq + 8'd1;
            end else begin
              r_idx  <= w_sel_idx;
              r_data <= w_byte;
            end
          end
        end
      endcase
    end
  end

  assign frame_ready = rst_n && (r_state == S_IDLE);
  assign busy        = (r_state == S_SEND);
  assign wr          = r_wr;
  assign data_out    = r_data;
  assign frame_count = r_count;

endmodule

// File: tb/tb_ft2232h_frame_tx.sv
// Directed bench for ft2232h_frame_tx: three parameterisations sharing clock and reset.
module tb_ft2232h_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [23:0] a_data;
  logic        a_valid, a_ready, a_txe, a_wr, a_busy;
  logic [7:0]  a_dout;
  logic [15:0] a_cnt;

  logic [13:0] b_data;
  logic        b_valid, b_ready, b_txe, b_wr, b_busy;
  logic [7:0]  b_dout;
  logic [15:0] b_cnt;

  logic [4:0]  c_data;
  logic        c_valid, c_ready, c_txe, c_wr, c_busy;
  logic [7:0]  c_dout;
  logic [15:0] c_cnt;

  ft2232h_frame_tx #(.DATA_WIDTH(12), .NUM_SAMPLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .frame_data(a_data), .frame_valid(a_valid),
    .frame_ready(a_ready), .txe(a_txe), .wr(a_wr), .data_out(a_dout),
    .busy(a_busy), .frame_count(a_cnt)
  );

  ft2232h_frame_tx #(.DATA_WIDTH(14), .NUM_SAMPLES(1), .HEADER_EN(0), .SEQ_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_data(b_data), .frame_valid(b_valid),
    .frame_ready(b_ready), .txe(b_txe), .wr(b_wr), .data_out(b_dout),
    .busy(b_busy), .frame_count(b_cnt)
  );

  ft2232h_frame_tx #(.DATA_WIDTH(5), .NUM_SAMPLES(1), .HEADER_EN(0), .SEQ_EN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .frame_data(c_data), .frame_valid(c_valid),
    .frame_ready(c_ready), .txe(c_txe), .wr(c_wr), .data_out(c_dout),
    .busy(c_busy), .frame_count(c_cnt)
  );

  int checks   = 0;
  int failures = 0;
  logic [7:0] cap[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Records bytes of dut_a on transfer edges until wr returns high or max_x bytes are taken.
  task automatic cap_a(input int max_x, input int stall_at, input int stall_len,
                       input logic [7:0] hold);
    int stalled = 0;
    bit done    = 1'b0;
    cap.delete();
    for (int c = 0; c < 200; c++) begin
      if (cap.size() >= max_x) begin
        done = 1'b1;
        break;
      end
      if (cap.size() == stall_at && stalled < stall_len) begin
        a_txe = 1'b1;
        stalled++;
        chk("stall_hold_data", 32'(a_dout), 32'(hold));
        chk("stall_hold_wr", 32'(a_wr), 32'd0);
      end else begin
        a_txe = 1'b0;
      end
      if (!a_wr && !a_txe) cap.push_back(a_dout);
      tick();
      if (a_wr) begin
        done = 1'b1;
        break;
      end
    end
    a_txe = 1'b0;
    chk("capture_done", 32'(done), 32'd1);
  endtask

  task automatic chk_frame(input string tag, input logic [39:0] exp);
    logic [7:0] b;
    chk({tag, "_len"}, 32'(cap.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      b = (i < cap.size()) ? cap[i] : 8'hxx;
      chk($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp[39-8*i -: 8]));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    a_data  = 24'hABC123; a_valid = 1'b0; a_txe = 1'b0;
    b_data  = 14'h3FFF;   b_valid = 1'b0; b_txe = 1'b0;
    c_data  = 5'h15;      c_valid = 1'b0; c_txe = 1'b0;

    #12;
    chk("rst_wr", 32'(a_wr), 32'd1);
    chk("rst_data", 32'(a_dout), 32'h00);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_count", 32'(a_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_ready", 32'(a_ready), 32'd1);
    chk("idle_busy", 32'(a_busy), 32'd0);
    chk("idle_wr", 32'(a_wr), 32'd1);

    // Frame 1: plain transfer
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    chk("start_wr", 32'(a_wr), 32'd0);
    chk("start_data", 32'(a_dout), 32'hFF);
    chk("start_busy", 32'(a_busy), 32'd1);
    chk("start_ready", 32'(a_ready), 32'd0);
    cap_a(99, -1, 0, 8'h00);
    chk_frame("f1", 40'hFF00ABC123);
    chk("f1_end_wr", 32'(a_wr), 32'd1);
    chk("f1_count", 32'(a_cnt), 32'd1);
    chk("f1_end_busy", 32'(a_busy), 32'd0);

    // Frame 2: txe stalls for 3 cycles after AB
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    cap_a(99, 3, 3, 8'hC1);
    chk_frame("f2_stall", 40'hFF01ABC123);
    chk("f2_count", 32'(a_cnt), 32'd2);

    // Frames 3 and 4 back-to-back; data changed mid-send only affects frame 4
    a_valid = 1'b1;
    tick();
    a_data = 24'h123456;
    cap_a(99, -1, 0, 8'h00);
    chk_frame("f3", 40'hFF02ABC123);
    chk("gap_wr", 32'(a_wr), 32'd1);
    chk("gap_ready", 32'(a_ready), 32'd1);
    tick();
    chk("b2b_wr", 32'(a_wr), 32'd0);
    chk("b2b_data", 32'(a_dout), 32'hFF);
    a_valid = 1'b0;
    cap_a(99, -1, 0, 8'h00);
    chk_frame("f4", 40'hFF03123456);
    chk("f4_count", 32'(a_cnt), 32'd4);

    // Reset mid-frame after two transfers
    a_data  = 24'hABC123;
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    cap_a(2, -1, 0, 8'h00);
    chk("mid_xfers", 32'(cap.size()), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(a_wr), 32'd1);
    chk("mid_rst_data", 32'(a_dout), 32'h00);
    chk("mid_rst_busy", 32'(a_busy), 32'd0);
    chk("mid_rst_ready", 32'(a_ready), 32'd0);
    chk("mid_rst_count", 32'(a_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_quiet", 32'(a_wr), 32'd1);
    end
    a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    cap_a(99, -1, 0, 8'h00);
    chk_frame("post_rst", 40'hFF00ABC123);
    chk("post_rst_count", 32'(a_cnt), 32'd1);

    // Run to 256 frames, then check the sequence number wrapped
    a_valid = 1'b1;
    for (int f = 0; f < 255; f++) begin
      tick();
      cap_a(99, -1, 0, 8'h00);
    end
    chk("count_256", 32'(a_cnt), 32'd256);
    tick();
    a_valid = 1'b0;
    cap_a(99, -1, 0, 8'h00);
    chk_frame("f257", 40'hFF00ABC123);
    chk("count_257", 32'(a_cnt), 32'd257);

    // Payload-only 14-bit frame: two bytes, last one zero-filled
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    chk("b_byte0_wr", 32'(b_wr), 32'd0);
    chk("b_byte0", 32'(b_dout), 32'hFF);
    chk("b_busy", 32'(b_busy), 32'd1);
    tick();
    chk("b_byte1_wr", 32'(b_wr), 32'd0);
    chk("b_byte1", 32'(b_dout), 32'hFC);
    tick();
    chk("b_end_wr", 32'(b_wr), 32'd1);
    chk("b_count", 32'(b_cnt), 32'd1);

    // Single-byte frame: 5'h15 left-justified
    c_valid = 1'b1;
    tick();
    c_valid = 1'b0;
    chk("c_byte0_wr", 32'(c_wr), 32'd0);
    chk("c_byte0", 32'(c_dout), 32'hA8);
    tick();
    chk("c_end_wr", 32'(c_wr), 32'd1);
    chk("c_count", 32'(c_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ft2232h_frame_tx.md
FT2232H_FRAME_TX -- requirements
Module: ft2232h_frame_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 14, SHALL set the bits per sample.
REQ-002 Parameter NUM_SAMPLES, default 40, SHALL set the samples per frame.
REQ-003 Parameter HEADER_EN, default 1, SHALL insert one header byte per frame when 1.
REQ-004 Parameter HEADER_BYTE, default 8'hFF, SHALL set the header byte value.
REQ-005 Parameter SEQ_EN, default 1, SHALL insert one sequence-number byte after the header when 1.
REQ-006 clk  input  1  SHALL be the single clock, the FT2232H 60 MHz CLKOUT; all logic on rising edge.
REQ-007 rst_n  input  1  SHALL be the reset: asynchronous assert, active-low, synchronous deassert by the integrator.
REQ-008 frame_data  input  DATA_WIDTH*NUM_SAMPLES  SHALL carry the frame payload; sample 0 occupies the MSBs.
REQ-009 frame_valid  input  1  SHALL indicate that frame_data is valid.
REQ-010 frame_ready  output  1  SHALL indicate that a frame is accepted this edge if frame_valid=1.
REQ-011 txe  input  1  SHALL be the FT2232H TXE#; low = FIFO has space.
REQ-012 wr  output  1  SHALL be the FT2232H WR#, active-low.
REQ-013 data_out  output  8  SHALL drive the FT2232H data bus.
REQ-014 busy  output  1  SHALL be high while a frame is in transmission.
REQ-015 frame_count  output  16  SHALL count completed frames.

Function
REQ-016 Derived constants: PAYLOAD_BYTES=ceil(DATA_WIDTH*NUM_SAMPLES/8); FRAME_BYTES=PAYLOAD_BYTES+HEADER_EN+SEQ_EN.
REQ-017 Payload bytes SHALL go out MSB-first from frame_data; a partial last byte SHALL be left-justified with zero-filled LSBs.
REQ-018 Byte order SHALL be: header (if enabled), sequence number (if enabled), then payload byte 0..PAYLOAD_BYTES-1.
REQ-019 States SHALL be exactly IDLE and SEND.
REQ-020 IDLE: frame_ready=1, wr=1, busy=0.
- On frame_valid=1: latch frame_data into an internal buffer.
- Next cycle: state=SEND, wr=0, data_out=byte 0.
REQ-021 SEND: frame_ready=0, busy=1, wr=0.
REQ-022 A byte SHALL count as transferred only at an edge with wr=0 and txe=0.
REQ-023 At a transfer edge with bytes remaining, data_out SHALL advance to the next byte.
REQ-024 txe=1 during SEND SHALL hold data_out and the byte index unchanged.
- wr stays 0.
- Transfer resumes at the first edge with txe=0.
- No byte is repeated or skipped.
REQ-025 At the transfer edge of the last byte:
- state=IDLE, wr=1.
- frame_count increments, wrapping 16'hFFFF->0.
- The sequence number increments, wrapping 8'hFF->0.
REQ-026 Back-to-back frames SHALL have exactly one IDLE cycle (wr=1) between the last byte of one frame and byte 0 of the next.
REQ-027 frame_data changes during SEND SHALL NOT affect the frame being sent.
REQ-028 The byte index counter SHALL be $clog2(FRAME_BYTES+1) bits wide and SHALL never exceed FRAME_BYTES-1.
REQ-029 With HEADER_EN=0 and SEQ_EN=0, the frame SHALL be payload only; PAYLOAD_BYTES=1 SHALL be supported.

Reset
REQ-030 rst_n=0 SHALL immediately force:
- state=IDLE, wr=1, data_out=8'h00, busy=0.
- frame_count=0, sequence number=0, byte index=0.
- frame_ready=0 while rst_n=0.
REQ-031 Reset mid-frame SHALL abandon the frame; no further bytes of it SHALL be sent after release.

Verification
REQ-032 DATA_WIDTH=12, NUM_SAMPLES=2, defaults, txe=0, frame_data=24'hABC123 -> FF,00,AB,C1,23 on consecutive transfer edges; then wr=1; frame_count=1.
REQ-033 Same frame, txe=1 for 3 cycles after the AB transfer -> data_out holds C1 with wr=0; C1 transfers at the first edge with txe=0; total 5 transfers.
REQ-034 Two frames back-to-back, frame_valid held -> second frame sequence byte=01; exactly one wr=1 cycle between frames.
REQ-035 DATA_WIDTH=14, NUM_SAMPLES=1, HEADER_EN=0, SEQ_EN=0, frame_data=14'h3FFF -> FF,FC.
REQ-036 rst_n pulsed low after 2 transfers -> wr=1 and data_out=00 without waiting for clk; next frame starts with header FF and sequence byte 00.
REQ-037 256 frames sent -> sequence byte of frame 257 = 00; frame_count=256.
